// File: rtl/fma_sched_pkg.sv
// rtl/fma_sched_pkg.sv - shared types and default sizes for the FMA exponent scheduler
package fma_sched_pkg;

  localparam int DEF_NE   = 11;
  localparam int DEF_BIAS = 1023;
  localparam int DEF_NREQ = 2;
  localparam int DEF_TAGW = 3;
  localparam int IDW      = $clog2(DEF_NREQ);

  typedef struct packed {
    logic [DEF_NE-1:0]   Xe;
    logic [DEF_NE-1:0]   Ye;
    logic                XZero;
    logic                YZero;
    logic [DEF_TAGW-1:0] Tag;
  } fmaexp_req_t;

endpackage

// File: rtl/fma_exp_sched_if.sv
// rtl/fma_exp_sched_if.sv - requester and response bundle for fma_exp_sched
interface fma_exp_sched_if #(
  parameter int NE   = 11,
  parameter int NREQ = 2,
  parameter int TAGW = 3
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]      ReqValid;
  logic [NREQ-1:0]      ReqReady;
  logic [NREQ*NE-1:0]   ReqXe;
  logic [NREQ*NE-1:0]   ReqYe;
  logic [NREQ-1:0]      ReqXZero;
  logic [NREQ-1:0]      ReqYZero;
  logic [NREQ*TAGW-1:0] ReqTag;
  logic                 Flush;
  logic                 RspValid;
  logic                 RspReady;
  logic [NE+1:0]        RspPe;
  logic [ID_W-1:0]      RspId;
  logic [TAGW-1:0]      RspTag;

  modport master (
    output ReqValid, ReqXe, ReqYe, ReqXZero, ReqYZero, ReqTag, Flush, RspReady,
    input  ReqReady, RspValid, RspPe, RspId, RspTag
  );

  modport slave (
    input  ReqValid, ReqXe, ReqYe, ReqXZero, ReqYZero, ReqTag, Flush, RspReady,
    output ReqReady, RspValid, RspPe, RspId, RspTag
  );
endinterface

// File: rtl/fma_exp_sched_rr_arbiter.sv
// rtl/fma_exp_sched_rr_arbiter.sv - round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    int j;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fma_exp_sched.sv
// rtl/fma_exp_sched.sv - shares one product-exponent adder among NREQ requesters
// Two-stage valid/ready pipeline: stage 1 holds the granted operands, stage 2 holds Pe/id/tag.
module fma_exp_sched
  import fma_sched_pkg::*;
#(
  parameter int NE   = DEF_NE,
  parameter int BIAS = DEF_BIAS,
  parameter int NREQ = DEF_NREQ,
  parameter int TAGW = DEF_TAGW
) (
  input logic            clk,
  input logic            reset,
  fma_exp_sched_if.slave bus
);

  localparam int ID_W = $clog2(NREQ);
  localparam logic [NE-1:0] BIAS_T = BIAS[NE-1:0];

  logic            v1_q, v1_d, v2_q, v2_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [NE-1:0]   xe1_q, ye1_q;
  logic            xz1_q, yz1_q;
  logic [ID_W-1:0] id1_q;
  logic [TAGW-1:0] tag1_q;
  logic [NE+1:0]   pe2_q;
  logic [ID_W-1:0] id2_q;
  logic [TAGW-1:0] tag2_q;

  logic            adv1, adv2, open, accept, any;
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] idx;
  logic [NE+1:0]   pe;

  rr_arbiter #(.NREQ(NREQ), .IW(ID_W)) u_arb (
    .req_i   (bus.ReqValid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (idx),
    .any_o   (any)
  );

  assign adv2   = ~v2_q | bus.RspReady;
  assign adv1   = ~v1_q | adv2;
  assign open   = adv1 & ~bus.Flush & ~reset;
  assign accept = open & any;

  assign bus.ReqReady = open ? grant : '0;
  assign bus.RspValid = v2_q;
  assign bus.RspPe    = pe2_q;
  assign bus.RspId    = id2_q;
  assign bus.RspTag   = tag2_q;

  // Modular subtraction: results below zero wrap, leaving the MSB as a sign bit.
  assign pe = (xz1_q | yz1_q) ? '0 : {2'b0, xe1_q} + {2'b0, ye1_q} - {2'b0, BIAS_T};

  always_comb begin
    v1_d  = v1_q;
    v2_d  = v2_q;
    ptr_d = ptr_q;
    if (bus.Flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      if (adv1) v1_d = accept;
      if (adv2) v2_d = v1_q;
      if (accept) ptr_d = (idx == ID_W'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      ptr_q  <= '0;
      xe1_q  <= '0;
      ye1_q  <= '0;
      xz1_q  <= 1'b0;
      yz1_q  <= 1'b0;
      id1_q  <= '0;
      tag1_q <= '0;
      pe2_q  <= '0;
      id2_q  <= '0;
      tag2_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      ptr_q <= ptr_d;
      if (accept) begin
        xe1_q  <= bus.ReqXe[idx*NE +: NE];
        ye1_q  <= bus.ReqYe[idx*NE +: NE];
        xz1_q  <= bus.ReqXZero[idx];
        yz1_q  <= bus.ReqYZero[idx];
        id1_q  <= idx;
        tag1_q <= bus.ReqTag[idx*TAGW +: TAGW];
      end
      // Flush freezes the data registers; only the valids are cleared.
      if (adv2 && v1_q && !bus.Flush) begin
        pe2_q  <= pe;
        id2_q  <= id1_q;
        tag2_q <= tag1_q;
      end
    end
  end

endmodule

// File: tb/tb_fma_exp_sched.sv
// tb/tb_fma_exp_sched.sv - directed self-checking bench for fma_exp_sched
module tb_fma_exp_sched;
  import fma_sched_pkg::*;

  localparam int NE   = 11;
  localparam int NREQ = 2;
  localparam int TAGW = 3;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  fma_exp_sched_if #(.NE(NE), .NREQ(NREQ), .TAGW(TAGW)) bus ();

  fma_exp_sched #(.NE(NE), .BIAS(1023), .NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int i, input fmaexp_req_t r);
    bus.ReqXe[i*NE +: NE]       = r.Xe;
    bus.ReqYe[i*NE +: NE]       = r.Ye;
    bus.ReqXZero[i]             = r.XZero;
    bus.ReqYZero[i]             = r.YZero;
    bus.ReqTag[i*TAGW +: TAGW]  = r.Tag;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ReqValid = 2'b11;
    step();
    tests_run++;
    if (bus.ReqReady !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_reqready got=%b exp=00", bus.ReqReady);
    end
    tests_run++;
    if (bus.RspValid !== 1'b0 || bus.RspPe !== 13'h0 || bus.RspId !== 1'b0 || bus.RspTag !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got v=%b pe=%h id=%h tag=%h exp all 0",
               bus.RspValid, bus.RspPe, bus.RspId, bus.RspTag);
    end
    bus.ReqValid = 2'b00;
    reset = 1'b0;
    step();
    bus.ReqValid = 2'b01;
    #1;
    tests_run++;
    if (bus.ReqReady !== 2'b01) begin
      tests_failed++;
      $display("FAIL post_reset_grant got=%b exp=01", bus.ReqReady);
    end
    bus.ReqValid = 2'b00;
  endtask

  task automatic test_datapath();
    int          ids[5];
    fmaexp_req_t vec[5];
    logic [12:0] exp_pe[5];
    logic [1:0]  oh;
    ids[0] = 0; vec[0] = '{11'h3FF, 11'h3FF, 1'b0, 1'b0, 3'd1}; exp_pe[0] = 13'h03FF;
    ids[1] = 0; vec[1] = '{11'h7FE, 11'h7FE, 1'b0, 1'b0, 3'd2}; exp_pe[1] = 13'h0BFD;
    ids[2] = 0; vec[2] = '{11'h001, 11'h001, 1'b0, 1'b0, 3'd3}; exp_pe[2] = 13'h1C03;
    ids[3] = 1; vec[3] = '{11'h400, 11'h500, 1'b1, 1'b0, 3'd6}; exp_pe[3] = 13'h0000;
    ids[4] = 1; vec[4] = '{11'h7FF, 11'h7FF, 1'b0, 1'b1, 3'd7}; exp_pe[4] = 13'h0000;
    bus.RspReady = 1'b1;
    for (int v = 0; v < 5; v++) begin
      drive(ids[v], vec[v]);
      oh = 2'b01 << ids[v];
      bus.ReqValid = oh;
      #1;
      tests_run++;
      if (bus.ReqReady !== oh) begin
        tests_failed++;
        $display("FAIL dp%0d_reqready got=%b exp=%b", v, bus.ReqReady, oh);
      end
      step();
      bus.ReqValid = 2'b00;
      tests_run++;
      if (bus.RspValid !== 1'b0) begin
        tests_failed++;
        $display("FAIL dp%0d_latency1 got RspValid=%b exp=0", v, bus.RspValid);
      end
      step();
      tests_run++;
      if (bus.RspValid !== 1'b1 || bus.RspPe !== exp_pe[v] || bus.RspId !== ids[v][0] ||
          bus.RspTag !== vec[v].Tag) begin
        tests_failed++;
        $display("FAIL dp%0d_result got v=%b pe=%h id=%h tag=%h exp v=1 pe=%h id=%0d tag=%h",
                 v, bus.RspValid, bus.RspPe, bus.RspId, bus.RspTag, exp_pe[v], ids[v], vec[v].Tag);
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic [12:0] exp_pe;
    int          rid;
    drive(0, '{11'h400, 11'h3FF, 1'b0, 1'b0, 3'd2});
    drive(1, '{11'h500, 11'h3FF, 1'b0, 1'b0, 3'd5});
    bus.RspReady = 1'b1;
    bus.ReqValid = 2'b11;
    for (int c = 0; c < 9; c++) begin
      if (c == 6) bus.ReqValid = 2'b00;
      #1;
      if (c < 6) begin
        exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
        tests_run++;
        if (bus.ReqReady !== exp_rdy) begin
          tests_failed++;
          $display("FAIL rr_grant%0d got=%b exp=%b", c, bus.ReqReady, exp_rdy);
        end
      end
      if (c >= 2 && c < 8) begin
        rid    = (c - 2) % 2;
        exp_pe = (rid == 0) ? 13'h0400 : 13'h0500;
        tests_run++;
        if (bus.RspValid !== 1'b1 || bus.RspId !== rid[0] || bus.RspPe !== exp_pe ||
            bus.RspTag !== ((rid == 0) ? 3'd2 : 3'd5)) begin
          tests_failed++;
          $display("FAIL rr_result%0d got v=%b id=%h pe=%h tag=%h exp v=1 id=%0d pe=%h",
                   c - 2, bus.RspValid, bus.RspId, bus.RspPe, bus.RspTag, rid, exp_pe);
        end
      end
      if (c == 8) begin
        tests_run++;
        if (bus.RspValid !== 1'b0) begin
          tests_failed++;
          $display("FAIL rr_drained got RspValid=%b exp=0", bus.RspValid);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    bus.RspReady = 1'b0;
    bus.ReqValid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.ReqReady != 2'b00) accepts++;
      if (c >= 2) begin
        tests_run++;
        if (bus.ReqReady !== 2'b00 || bus.RspValid !== 1'b1 || bus.RspPe !== 13'h0400) begin
          tests_failed++;
          $display("FAIL bp_stall%0d got rdy=%b v=%b pe=%h exp rdy=00 v=1 pe=0400",
                   c, bus.ReqReady, bus.RspValid, bus.RspPe);
        end
      end
      step();
    end
    tests_run++;
    if (accepts != 2) begin
      tests_failed++;
      $display("FAIL bp_accepts got=%0d exp=2", accepts);
    end
    bus.ReqValid = 2'b00;
    bus.RspReady = 1'b1;
    #1;
    tests_run++;
    if (bus.RspValid !== 1'b1 || bus.RspId !== 1'b0 || bus.RspPe !== 13'h0400) begin
      tests_failed++;
      $display("FAIL bp_drain0 got v=%b id=%h pe=%h exp v=1 id=0 pe=0400",
               bus.RspValid, bus.RspId, bus.RspPe);
    end
    step();
    tests_run++;
    if (bus.RspValid !== 1'b1 || bus.RspId !== 1'b1 || bus.RspPe !== 13'h0500) begin
      tests_failed++;
      $display("FAIL bp_drain1 got v=%b id=%h pe=%h exp v=1 id=1 pe=0500",
               bus.RspValid, bus.RspId, bus.RspPe);
    end
    step();
    tests_run++;
    if (bus.RspValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_empty got RspValid=%b exp=0", bus.RspValid);
    end
  endtask

  task automatic test_flush();
    bus.RspReady = 1'b0;
    bus.ReqValid = 2'b11;
    step();
    step();
    bus.Flush    = 1'b1;
    bus.RspReady = 1'b1;
    #1;
    tests_run++;
    if (bus.ReqReady !== 2'b00) begin
      tests_failed++;
      $display("FAIL flush_no_accept got=%b exp=00", bus.ReqReady);
    end
    step();
    bus.Flush = 1'b0;
    #1;
    tests_run++;
    if (bus.RspValid !== 1'b0 || bus.RspPe !== 13'h0400 || bus.ReqReady !== 2'b01) begin
      tests_failed++;
      $display("FAIL flush_after got v=%b pe=%h rdy=%b exp v=0 pe=0400 rdy=01",
               bus.RspValid, bus.RspPe, bus.ReqReady);
    end
    bus.ReqValid = 2'b00;
    step();
    step();
    tests_run++;
    if (bus.RspValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_leak got RspValid=%b exp=0", bus.RspValid);
    end
  endtask

  task automatic test_reset_midstream();
    bus.RspReady = 1'b0;
    bus.ReqValid = 2'b01;
    step();
    step();
    tests_run++;
    if (bus.ReqReady !== 2'b00 || bus.RspValid !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_state got rdy=%b v=%b exp rdy=00 v=1", bus.ReqReady, bus.RspValid);
    end
    reset = 1'b1;
    step();
    tests_run++;
    if (bus.RspValid !== 1'b0 || bus.RspPe !== 13'h0 || bus.RspId !== 1'b0 ||
        bus.RspTag !== 3'd0 || bus.ReqReady !== 2'b00) begin
      tests_failed++;
      $display("FAIL midreset_outputs got v=%b pe=%h id=%h tag=%h rdy=%b exp all 0",
               bus.RspValid, bus.RspPe, bus.RspId, bus.RspTag, bus.ReqReady);
    end
    reset = 1'b0;
    bus.ReqValid = 2'b11;
    #1;
    tests_run++;
    if (bus.ReqReady !== 2'b01) begin
      tests_failed++;
      $display("FAIL midreset_ptr got=%b exp=01", bus.ReqReady);
    end
    bus.ReqValid = 2'b00;
    step();
  endtask

  initial begin
    reset        = 1'b1;
    bus.ReqValid = '0;
    bus.ReqXe    = '0;
    bus.ReqYe    = '0;
    bus.ReqXZero = '0;
    bus.ReqYZero = '0;
    bus.ReqTag   = '0;
    bus.Flush    = 1'b0;
    bus.RspReady = 1'b1;
    @(negedge clk);
    test_reset();
    test_datapath();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
